// File: rtl/cpu_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_status_ctrl
// Brief    : CPU status/flags registers, halt/DMA sequencing, interrupt
//            save/restore and user-mode status write protection.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_status_ctrl #(
    parameter logic [7:0] STATUS_RESET = 8'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       status_wr,
    input  logic [7:0] status_wdata,
    input  logic       flags_wr,
    input  logic [3:0] flags_wdata,
    input  logic       alu_flags_load,
    input  logic [3:0] alu_flags_in,
    input  logic       instr_boundary,
    input  logic       halt_set,
    input  logic       irq_req,
    input  logic       irq_ack,
    input  logic       status_restore,
    input  logic       dma_req,
    output logic [7:0] status_out,
    output logic [3:0] flags_out,
    output logic [7:0] saved_status,
    output logic       irq_pending,
    output logic       cpu_stall,
    output logic       prot_fault
);

    localparam logic [1:0] c_st_run  = 2'd0;
    localparam logic [1:0] c_st_halt = 2'd1;
    localparam logic [1:0] c_st_dma  = 2'd2;

    // Bits software may own: irq_en, mode, paging_en, displayreg_load, dir
    localparam logic [7:0] c_sw_mask   = 8'hAE;
    // Bits a user-mode write must not change: irq_en, mode, paging_en, displayreg_load
    localparam logic [7:0] c_prot_mask = 8'h2E;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_ret_halt;
    logic       w_ret_halt_nxt;
    logic [7:0] r_sw;
    logic [7:0] w_sw_nxt;
    logic       w_fault;
    logic [7:0] r_saved;
    logic [3:0] r_flags;
    logic       r_irq_pending;
    logic       r_prot_fault;
    logic       w_halt_bit;
    logic       w_dma_bit;

    always_comb begin
        w_state_nxt    = r_state;
        w_ret_halt_nxt = r_ret_halt;
        case (r_state)
            c_st_run: begin
                if (dma_req && instr_boundary) begin
                    w_state_nxt    = c_st_dma;
                    // A coincident HLT is deferred until the DMA transfer ends
                    w_ret_halt_nxt = halt_set;
                end else if (halt_set) begin
                    w_state_nxt = c_st_halt;
                end
            end
            c_st_halt: begin
                if (dma_req) begin
                    w_state_nxt    = c_st_dma;
                    w_ret_halt_nxt = 1'b1;
                end else if (r_irq_pending) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_dma: begin
                if (!dma_req) begin
                    w_state_nxt    = r_ret_halt ? c_st_halt : c_st_run;
                    w_ret_halt_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = c_st_run;
                w_ret_halt_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        // displayreg_load self-clears unless rewritten this cycle
        w_sw_nxt = r_sw & ~8'h20;
        w_fault  = 1'b0;
        if (irq_ack) begin
            w_sw_nxt = (r_sw & ~8'h22) | 8'h04;
        end else if (status_restore) begin
            w_sw_nxt = r_saved & c_sw_mask;
        end else if (status_wr) begin
            if (r_sw[2]) begin
                w_sw_nxt = status_wdata & c_sw_mask;
            end else begin
                w_sw_nxt[7] = status_wdata[7];
                w_fault     = |((status_wdata ^ r_sw) & c_prot_mask);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_run;
            r_ret_halt    <= 1'b0;
            r_sw          <= STATUS_RESET & c_sw_mask;
            r_saved       <= 8'h00;
            r_flags       <= 4'h0;
            r_irq_pending <= 1'b0;
            r_prot_fault  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ret_halt    <= w_ret_halt_nxt;
            r_sw          <= w_sw_nxt;
            r_irq_pending <= irq_req & r_sw[1];
            r_prot_fault  <= w_fault;
            if (irq_ack) begin
                r_saved <= status_out;
            end
            if (flags_wr) begin
                r_flags <= flags_wdata;
            end else if (alu_flags_load) begin
                r_flags <= alu_flags_in;
            end
        end
    end

    assign w_halt_bit   = (r_state == c_st_halt);
    assign w_dma_bit    = (r_state == c_st_dma);
    assign status_out   = r_sw | {3'b000, w_halt_bit, 3'b000, w_dma_bit};
    assign flags_out    = r_flags;
    assign saved_status = r_saved;
    assign irq_pending  = r_irq_pending;
    assign cpu_stall    = (r_state != c_st_run);
    assign prot_fault   = r_prot_fault;

endmodule
`default_nettype wire

// File: tb/tb_cpu_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_status_ctrl
// Brief    : Directed self-checking bench for cpu_status_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_status_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       status_wr;
    logic [7:0] status_wdata;
    logic       flags_wr;
    logic [3:0] flags_wdata;
    logic       alu_flags_load;
    logic [3:0] alu_flags_in;
    logic       instr_boundary;
    logic       halt_set;
    logic       irq_req;
    logic       irq_ack;
    logic       status_restore;
    logic       dma_req;
    logic [7:0] status_out;
    logic [3:0] flags_out;
    logic [7:0] saved_status;
    logic       irq_pending;
    logic       cpu_stall;
    logic       prot_fault;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_status_ctrl #(.STATUS_RESET(8'h04)) dut (
        .clk            (clk),
        .rst            (rst),
        .status_wr      (status_wr),
        .status_wdata   (status_wdata),
        .flags_wr       (flags_wr),
        .flags_wdata    (flags_wdata),
        .alu_flags_load (alu_flags_load),
        .alu_flags_in   (alu_flags_in),
        .instr_boundary (instr_boundary),
        .halt_set       (halt_set),
        .irq_req        (irq_req),
        .irq_ack        (irq_ack),
        .status_restore (status_restore),
        .dma_req        (dma_req),
        .status_out     (status_out),
        .flags_out      (flags_out),
        .saved_status   (saved_status),
        .irq_pending    (irq_pending),
        .cpu_stall      (cpu_stall),
        .prot_fault     (prot_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; status_wr = 1'b0; status_wdata = 8'h00; flags_wr = 1'b0;
        flags_wdata = 4'h0; alu_flags_load = 1'b0; alu_flags_in = 4'h0;
        instr_boundary = 1'b0; halt_set = 1'b0; irq_req = 1'b0; irq_ack = 1'b0;
        status_restore = 1'b0; dma_req = 1'b0;
        tick(); tick();
        chk("rst_status", status_out, 8'h04);
        chk("rst_flags", {4'h0, flags_out}, 8'h00);
        chk("rst_saved", saved_status, 8'h00);
        chk("rst_stall", {7'h0, cpu_stall}, 8'h00);
        chk("rst_fault", {7'h0, prot_fault}, 8'h00);
        chk("rst_pend", {7'h0, irq_pending}, 8'h00);
        rst = 1'b0;

        // Interrupts disabled after reset: request must not go pending
        irq_req = 1'b1; tick(); tick();
        chk("pend_gated", {7'h0, irq_pending}, 8'h00);
        irq_req = 1'b0;

        // Supervisor write: FSM bits and reserved bit are dropped
        status_wr = 1'b1; status_wdata = 8'hFF; tick();
        chk("sup_wr", status_out, 8'hAE);
        status_wr = 1'b0; tick();
        chk("disp_clear", status_out, 8'h8E);

        // Enter user mode, then illegal user write
        status_wr = 1'b1; status_wdata = 8'h02; tick();
        chk("to_user", status_out, 8'h02);
        status_wdata = 8'h8A; tick();
        chk("user_wr", status_out, 8'h82);
        chk("fault_hi", {7'h0, prot_fault}, 8'h01);
        status_wr = 1'b0; tick();
        chk("fault_lo", {7'h0, prot_fault}, 8'h00);
        chk("user_hold", status_out, 8'h82);

        // Interrupt entry from user mode returns to supervisor
        irq_ack = 1'b1; tick();
        chk("ack1_saved", saved_status, 8'h82);
        chk("ack1_status", status_out, 8'h84);
        irq_ack = 1'b0;
        status_wr = 1'b1; status_wdata = 8'h8E; tick();
        status_wr = 1'b0;
        chk("set_8e", status_out, 8'h8E);

        // irq_ack beats a simultaneous write and restore
        irq_req = 1'b1; tick();
        chk("pend_set", {7'h0, irq_pending}, 8'h01);
        irq_ack = 1'b1; status_wr = 1'b1; status_wdata = 8'h00; status_restore = 1'b1; tick();
        chk("ack2_saved", saved_status, 8'h8E);
        chk("ack2_status", status_out, 8'h8C);
        irq_ack = 1'b0; status_wr = 1'b0; tick();
        chk("iret", status_out, 8'h8E);
        status_restore = 1'b0; irq_req = 1'b0; tick(); tick();
        chk("pend_clr", {7'h0, irq_pending}, 8'h00);

        // HLT, wake on interrupt
        halt_set = 1'b1; tick(); halt_set = 1'b0;
        chk("halt_status", status_out, 8'h9E);
        chk("halt_stall", {7'h0, cpu_stall}, 8'h01);
        irq_req = 1'b1; tick();
        chk("halt_pend", {7'h0, irq_pending}, 8'h01);
        chk("halt_still", status_out, 8'h9E);
        tick();
        chk("wake_status", status_out, 8'h8E);
        chk("wake_stall", {7'h0, cpu_stall}, 8'h00);
        irq_req = 1'b0; tick(); tick();

        // DMA while halted returns to HALT
        halt_set = 1'b1; tick(); halt_set = 1'b0;
        dma_req = 1'b1; tick();
        chk("hdma_status", status_out, 8'h8F);
        chk("hdma_stall", {7'h0, cpu_stall}, 8'h01);
        dma_req = 1'b0; tick();
        chk("hdma_ret", status_out, 8'h9E);
        chk("hdma_ret_stall", {7'h0, cpu_stall}, 8'h01);
        irq_req = 1'b1; tick(); tick();
        chk("wake2", status_out, 8'h8E);
        irq_req = 1'b0; tick(); tick();

        // DMA at boundary and HLT together: DMA first, then HALT
        dma_req = 1'b1; instr_boundary = 1'b1; halt_set = 1'b1; tick();
        halt_set = 1'b0; instr_boundary = 1'b0;
        chk("prio_dma", status_out, 8'h8F);
        tick();
        chk("prio_dma_hold", status_out, 8'h8F);
        dma_req = 1'b0; tick();
        chk("prio_halt", status_out, 8'h9E);
        chk("prio_stall", {7'h0, cpu_stall}, 8'h01);
        irq_req = 1'b1; tick(); tick();
        chk("wake3", status_out, 8'h8E);
        irq_req = 1'b0; tick(); tick();

        // DMA needs a boundary while running
        dma_req = 1'b1; tick();
        chk("dma_nobnd", status_out, 8'h8E);

        // Flags: explicit write beats ALU load; irq_ack leaves flags alone
        flags_wr = 1'b1; flags_wdata = 4'hA; alu_flags_load = 1'b1; alu_flags_in = 4'h5; tick();
        chk("flags_prio", {4'h0, flags_out}, 8'h0A);
        flags_wr = 1'b0; alu_flags_in = 4'h3; tick();
        chk("flags_alu", {4'h0, flags_out}, 8'h03);
        alu_flags_load = 1'b0; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("flags_keep", {4'h0, flags_out}, 8'h03);

        // Reset in the middle of DMA
        instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
        chk("run_dma", {7'h0, status_out[0]}, 8'h01);
        chk("run_dma_stall", {7'h0, cpu_stall}, 8'h01);
        rst = 1'b1; tick();
        chk("dma_rst_status", status_out, 8'h04);
        chk("dma_rst_stall", {7'h0, cpu_stall}, 8'h00);
        chk("dma_rst_flags", {4'h0, flags_out}, 8'h00);
        rst = 1'b0; dma_req = 1'b0; tick();
        chk("post_rst", status_out, 8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_status_ctrl.md
Name: cpu_status_ctrl

Overview:
- Owns the CPU status register (8 bits) and the ALU flags register (4 bits).
- Uses the package bit positions: status dma_ack=0, irq_en=1, mode=2, paging_en=3, halt=4, displayreg_load=5, bit 6 reserved, dir=7; flags zf=0, cf=1, sf=2, of=3.
- Sits between the microcode sequencer/ALU and the rest of the CPU. It runs the halt/DMA state machine, interrupt entry/return save-restore and user-mode write protection.
- Its outputs feed paging, the interrupt controller and the display register.

Parameters:
- STATUS_RESET, 8'h04, status value after reset (supervisor mode, everything else 0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- status_wr  in  1  microcode write strobe for the status register
- status_wdata  in  8  status write data
- flags_wr  in  1  microcode/POPF write strobe for flags
- flags_wdata  in  4  flags write data
- alu_flags_load  in  1  latch ALU result flags
- alu_flags_in  in  4  ALU flags {of,sf,cf,zf}
- instr_boundary  in  1  sequencer is at an instruction fetch boundary
- halt_set  in  1  HLT executed (one-cycle pulse)
- irq_req  in  1  level interrupt request from the interrupt controller
- irq_ack  in  1  sequencer is entering the interrupt handler (pulse)
- status_restore  in  1  IRET: restore saved status (pulse)
- dma_req  in  1  external DMA request (level)
- status_out  out  8  current status register
- flags_out  out  4  current flags register
- saved_status  out  8  status captured at interrupt entry
- irq_pending  out  1  irq_req & irq_en, registered
- cpu_stall  out  1  sequencer must hold (HALT or DMA state)
- prot_fault  out  1  one-cycle pulse on an illegal user-mode status write

Behaviour:
- Reset (sync, highest priority):
  - status_out=STATUS_RESET, flags_out=0, saved_status=0.
  - irq_pending=0, cpu_stall=0, prot_fault=0, FSM=RUN.
  - rst mid-DMA or mid-HALT forces RUN and drops dma_ack on the next edge.
- FSM states: RUN, HALT, DMA. Bits 0 (dma_ack) and 4 (halt) are FSM-owned; software writes to those bits are ignored.
  - RUN→DMA: dma_req & instr_boundary. dma_ack is set on the same edge; cpu_stall=1 from the next cycle.
  - RUN→HALT: halt_set. Halt bit is set; cpu_stall=1.
  - HALT→DMA: dma_req, no boundary needed. The FSM records return-to-HALT.
  - HALT→RUN: irq_pending=1. Halt bit is cleared; cpu_stall drops the same edge.
  - DMA→RUN/HALT: dma_req=0. dma_ack is cleared; the FSM goes to RUN, or to HALT if DMA was entered from HALT.
  - Priority in RUN when dma_req&boundary and halt_set coincide: DMA first, then HALT after DMA returns (halt_set latched).
- irq_pending is registered: irq_req & status[1], one-cycle latency.
- Interrupt entry (irq_ack):
  - saved_status <= status_out.
  - Then status[2] (mode) <= 1, status[1] <= 0, status[4] <= 0.
  - Wins over a simultaneous status_wr and status_restore.
- IRET (status_restore):
  - status <= saved_status, except bit 0 (dma_ack), which keeps the FSM value.
  - Bit 4 (halt) is restored as 0.
- status_wr:
  - In supervisor mode (status[2]=1): bits 1,2,3,5,7 are written.
  - In user mode: only bit 7 (dir) is written. If any of bits 1,2,3,5 differs from current, prot_fault pulses one cycle and those bits are unchanged.
  - Bit 6 always reads 0.
- displayreg_load (bit 5): self-clearing. When written to 1 it reads 1 for exactly one cycle, then returns to 0 unless rewritten.
- Flags:
  - flags_wr has priority over alu_flags_load in the same cycle.
  - Writes are visible on flags_out the cycle after the strobe.
  - Flags are never altered by irq_ack or status_restore.
- All updates are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then supervisor status_wr 8'hFF → status_out=8'hAE on the next cycle (bits 0, 4, 6 cleared), with displayreg_load dropping after 1 cycle → 8'h8E.
- User mode (status=8'h02), status_wr 8'h8A → status=8'h82 and prot_fault pulses once.
- status=8'h8E, irq_req=1, irq_ack → saved_status=8'h8E, status=8'h8C. Then status_restore → status=8'h8E.
- halt_set with irq_en=1 → cpu_stall=1, status[4]=1. Raise irq_req → irq_pending next cycle and RUN on the following edge with status[4]=0.
- In HALT, dma_req=1 → dma_ack=1 with cpu_stall held. dma_req=0 → dma_ack=0 and back in HALT (status[4]=1).
- flags_wr 4'hA together with alu_flags_load 4'h5 → flags_out=4'hA. Assert rst during DMA → status=8'h04, FSM=RUN.
